// File: rtl/byte_serializer_p2s.sv
// byte_serializer_p2s
// Parallel-to-serial stage behind the 32b->8b word splitter. Incoming bytes
// are queued in a small FIFO and shifted out MSB-first, one bit per clk_32f.
// A free-running bit counter defines fixed-length frames; when the FIFO is
// empty at a frame boundary the idle/comma byte is sent so the line never
// stalls.
// Optional feature macro: PARITY_EN -- appends one even-parity bit to every
// frame (9-bit frames). Without it, frames are 8 bits and no parity logic
// exists.
module byte_serializer_p2s #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] IDLE_BYTE  = 8'hBC
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       valid_in,
   input  logic [7:0] data_in,
   output logic       in_ready,
   output logic       data_out,
   output logic       frame_start,
   output logic       frame_valid,
   output logic       overflow
);

`ifdef PARITY_EN
   localparam int SHIFT_W   = 9;
   localparam int FRAME_LEN = 9;
`else
   localparam int SHIFT_W   = 8;
   localparam int FRAME_LEN = 8;
`endif

   localparam int         PTR_W    = $clog2(FIFO_DEPTH);
   localparam int         CNT_W    = PTR_W + 1;
   localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

`ifdef PARITY_EN
   // Even parity: XOR of all data bits.
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

   // Frame image loaded into the shift register: data bits then parity bit.
   function automatic logic [SHIFT_W-1:0] frame_word(input logic [7:0] b);
      return {b, even_parity(b)};
   endfunction
`else
   // Frame image loaded into the shift register: data bits only.
   function automatic logic [SHIFT_W-1:0] frame_word(input logic [7:0] b);
      return b;
   endfunction
`endif

   logic [7:0]         mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [CNT_W-1:0]   count_r;
   logic [CNT_W-1:0]   count_next_s;
   logic [3:0]         bit_cnt_r;
   logic [SHIFT_W-1:0] shift_r;
   logic               frame_start_r;
   logic               frame_valid_r;
   logic               overflow_r;

   logic               full_s;
   logic               empty_s;
   logic               wr_en_s;
   logic               rd_en_s;
   logic               boundary_s;

   // FIFO status, accept/pop qualifiers and next occupancy.
   always_comb begin
      full_s       = 1'b0;
      empty_s      = 1'b0;
      wr_en_s      = 1'b0;
      rd_en_s      = 1'b0;
      boundary_s   = 1'b0;
      count_next_s = count_r;
      full_s       = (count_r == CNT_W'(FIFO_DEPTH));
      empty_s      = (count_r == {CNT_W{1'b0}});
      boundary_s   = (bit_cnt_r == LAST_BIT);
      // A write landing in an empty FIFO on the boundary cycle is not seen by
      // that load because the pop decision uses the pre-cycle count.
      wr_en_s      = valid_in && !full_s;
      rd_en_s      = boundary_s && !empty_s;
      case ({wr_en_s, rd_en_s})
         2'b10:   count_next_s = count_r + CNT_W'(1);
         2'b01:   count_next_s = count_r - CNT_W'(1);
         default: count_next_s = count_r;
      endcase
   end

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge clk_32f) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= data_in;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= {CNT_W{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_next_s;
         if (valid_in && full_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Bit counter, shift register and per-frame flags.
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         bit_cnt_r     <= 4'd0;
         shift_r       <= frame_word(IDLE_BYTE);
         frame_start_r <= 1'b1;
         frame_valid_r <= 1'b0;
      end else begin
         if (boundary_s) begin
            bit_cnt_r     <= 4'd0;
            frame_start_r <= 1'b1;
            if (!empty_s) begin
               shift_r       <= frame_word(mem_r[rd_ptr_r]);
               frame_valid_r <= 1'b1;
            end else begin
               shift_r       <= frame_word(IDLE_BYTE);
               frame_valid_r <= 1'b0;
            end
         end else begin
            bit_cnt_r     <= bit_cnt_r + 4'd1;
            shift_r       <= {shift_r[SHIFT_W-2:0], 1'b0};
            frame_start_r <= 1'b0;
            frame_valid_r <= frame_valid_r;
         end
      end
   end

   assign in_ready    = !full_s;
   assign data_out    = shift_r[SHIFT_W-1];
   assign frame_start = frame_start_r;
   assign frame_valid = frame_valid_r;
   assign overflow    = overflow_r;

endmodule
